// File: rtl/uart_pkg.sv
// Shared constants for the uart_component slice: register map, bit indices,
// interrupt ID codes and engine state encodings.
package uart_pkg;

  localparam logic [2:0] ADDR_CTL = 3'd0;
  localparam logic [2:0] ADDR_STS = 3'd1;
  localparam logic [2:0] ADDR_TXD = 3'd2;
  localparam logic [2:0] ADDR_RXD = 3'd3;
  localparam logic [2:0] ADDR_CLR = 3'd4;

  localparam int unsigned CTL_TX_DONE_IE  = 0;
  localparam int unsigned CTL_RX_AVAIL_IE = 1;
  localparam int unsigned CTL_RX_ERR_IE   = 2;
  localparam int unsigned CTL_LOOPBACK    = 3;

  localparam int unsigned STS_TX_BUSY     = 0;
  localparam int unsigned STS_RX_AVAIL    = 1;
  localparam int unsigned STS_FRAMING_ERR = 2;
  localparam int unsigned STS_OVERRUN     = 3;
  localparam int unsigned STS_TX_DONE     = 4;

  localparam logic [2:0] IRQ_NONE     = 3'd0;
  localparam logic [2:0] IRQ_RX_ERR   = 3'd1;
  localparam logic [2:0] IRQ_RX_AVAIL = 3'd2;
  localparam logic [2:0] IRQ_TX_DONE  = 3'd3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 transmit engine: start pulse latches a byte, shifts it out LSB first,
// and pulses done on the last cycle of the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       serial
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cnt == BIT_LAST);
  assign busy    = (state != TX_IDLE);
  assign done    = (state == TX_STOP) && bit_end;

  always_comb begin
    state_next = state;
    unique case (state)
      TX_IDLE:  if (start) state_next = TX_START;
      TX_START: if (bit_end) state_next = TX_DATA;
      TX_DATA:  if (bit_end && bit_idx == 3'd7) state_next = TX_STOP;
      TX_STOP:  if (bit_end) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      serial  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= (state == TX_IDLE || bit_end) ? '0 : cnt + 1'b1;
      // serial is registered, so each bit value is loaded one edge ahead of its slot
      case (state)
        TX_IDLE: if (start) begin
          shreg   <= data;
          bit_idx <= '0;
          serial  <= 1'b0;
        end
        TX_START: if (bit_end) serial <= shreg[0];
        TX_DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            serial <= 1'b1;
          end else begin
            serial  <= shreg[1];
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_component.sv
// Memory-mapped 8N1 UART: CTL/STS/TXD/RXD/CLR registers, RX engine, level irq.
// Optional UART_LOOPBACK_EN: CTL bit3 feeds TX serial into RX and holds tx_out high.
module uart_component
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       irq,
  output logic [2:0] irq_id
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          wr_act, rd_act, wr_act_q, rd_act_q, wr_first, rd_first, clr_hit;
  logic [3:0]    ctl;
  logic          loopback, tx_start, tx_busy, tx_end, tx_ser;
  logic          tx_done, rx_avail, framing_err, overrun, rx_err;
  logic [7:0]    rxd;
  logic [1:0]    rx_sync;
  logic          rx_prev, rx_src, rx_tick, rx_stop, set_ferr, set_ovr, set_avail;
  rx_state_e     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;

  assign wr_act   = ~cs & ~wr;
  assign rd_act   = ~cs & ~rd;
  assign wr_first = wr_act & ~wr_act_q;
  assign rd_first = rd_act & ~rd_act_q;
  assign clr_hit  = wr_act && addr == ADDR_CLR;
  assign tx_start = wr_first && addr == ADDR_TXD && !tx_busy;

`ifdef UART_LOOPBACK_EN
  assign loopback = ctl[CTL_LOOPBACK];
`else
  assign loopback = 1'b0;
`endif

  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock  (clock),
    .reset  (reset),
    .start  (tx_start),
    .data   (in_data),
    .busy   (tx_busy),
    .done   (tx_end),
    .serial (tx_ser)
  );

  assign tx_out = tx_ser | loopback;
  assign rx_src = loopback ? tx_ser : rx_in;

  always_comb begin
    rx_next = rx_state;
    rx_tick = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync[1]) rx_next = RX_START;
      RX_START: begin
        rx_tick = (rx_cnt == HALF_LAST);
        if (rx_tick) rx_next = rx_sync[1] ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        rx_tick = (rx_cnt == BIT_LAST);
        if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: begin
        rx_tick = (rx_cnt == BIT_LAST);
        if (rx_tick) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign rx_stop   = (rx_state == RX_STOP) && rx_tick;
  assign set_ferr  = rx_stop & ~rx_sync[1];
  assign set_ovr   = rx_stop & rx_sync[1] & rx_avail;
  assign set_avail = rx_stop & rx_sync[1] & ~rx_avail;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], rx_src};
      rx_prev  <= rx_sync[1];
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_tick && rx_state == RX_START) rx_bit <= '0;
      if (rx_tick && rx_state == RX_DATA) begin
        rx_shreg <= {rx_sync[1], rx_shreg[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // Flag sets take priority over CLR writes and RXD reads in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_act_q    <= 1'b0;
      rd_act_q    <= 1'b0;
      ctl         <= '0;
      rxd         <= '0;
      tx_done     <= 1'b0;
      rx_avail    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (wr_act && addr == ADDR_CTL) begin
`ifdef UART_LOOPBACK_EN
        ctl <= in_data[3:0];
`else
        ctl <= {1'b0, in_data[2:0]};
`endif
      end
      if (tx_end) tx_done <= 1'b1;
      else if (tx_start || (clr_hit && in_data[STS_TX_DONE])) tx_done <= 1'b0;
      if (set_ferr) framing_err <= 1'b1;
      else if (clr_hit && in_data[STS_FRAMING_ERR]) framing_err <= 1'b0;
      if (set_ovr) overrun <= 1'b1;
      else if (clr_hit && in_data[STS_OVERRUN]) overrun <= 1'b0;
      if (set_avail) begin
        rx_avail <= 1'b1;
        rxd      <= rx_shreg;
      end else if (rd_first && addr == ADDR_RXD) begin
        rx_avail <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (rd_act) begin
      case (addr)
        ADDR_CTL: out_data = {4'b0000, ctl};
        ADDR_STS: out_data = {3'b000, tx_done, overrun, framing_err, rx_avail, tx_busy};
        ADDR_RXD: out_data = rxd;
        default:  out_data = '0;
      endcase
    end
  end

  assign rx_err = framing_err | overrun;
  assign irq = (tx_done & ctl[CTL_TX_DONE_IE]) | (rx_avail & ctl[CTL_RX_AVAIL_IE]) |
               (rx_err & ctl[CTL_RX_ERR_IE]);

  always_comb begin
    irq_id = IRQ_NONE;
    if (rx_err & ctl[CTL_RX_ERR_IE]) irq_id = IRQ_RX_ERR;
    else if (rx_avail & ctl[CTL_RX_AVAIL_IE]) irq_id = IRQ_RX_AVAIL;
    else if (tx_done & ctl[CTL_TX_DONE_IE]) irq_id = IRQ_TX_DONE;
  end

endmodule

// File: tb/tb_uart_component.sv
// Bench for uart_component (CLKS_PER_BIT=8): register table, directed frame
// sequences and randomized RX/bus traffic against a flag-level reference model.
module tb_uart_component;
  localparam int unsigned CPB = 8;
  localparam logic [2:0] A_CTL = 3'd0, A_STS = 3'd1, A_TXD = 3'd2, A_RXD = 3'd3, A_CLR = 3'd4;
`ifdef UART_LOOPBACK_EN
  localparam logic [7:0] CTL_MASK = 8'h0F;
`else
  localparam logic [7:0] CTL_MASK = 8'h07;
`endif

  logic       clock = 1'b0;
  logic       reset, cs, rd, wr, rx_in, tx_out, irq;
  logic [2:0] addr, irq_id;
  logic [7:0] in_data, out_data;
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [2:0] m_ctl;
  logic       m_done, m_avail, m_ferr, m_ovr;
  logic [7:0] m_rxd;

  typedef struct {
    logic       we;
    logic [2:0] a;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clock = ~clock;

  uart_component #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .in_data(in_data), .out_data(out_data), .rx_in(rx_in), .tx_out(tx_out),
    .irq(irq), .irq_id(irq_id)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] m_sts();
    return {3'b000, m_done, m_ovr, m_ferr, m_avail, 1'b0};
  endfunction

  function automatic logic m_irq();
    return (m_done & m_ctl[0]) | (m_avail & m_ctl[1]) | ((m_ferr | m_ovr) & m_ctl[2]);
  endfunction

  function automatic logic [2:0] m_id();
    if ((m_ferr | m_ovr) & m_ctl[2]) return 3'd1;
    if (m_avail & m_ctl[1]) return 3'd2;
    if (m_done & m_ctl[0]) return 3'd3;
    return 3'd0;
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock); cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
    @(negedge clock); cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] v);
    @(negedge clock); cs = 1'b0; rd = 1'b0; addr = a;
    #1 v = out_data;
    @(negedge clock); cs = 1'b1; rd = 1'b1;
  endtask

  task automatic wr_ctl(input logic [7:0] v);
    bus_write(A_CTL, v & 8'h07);
    m_ctl = v[2:0];
  endtask

  task automatic clr(input logic [7:0] v);
    bus_write(A_CLR, v);
    if (v[2]) m_ferr = 1'b0;
    if (v[3]) m_ovr = 1'b0;
    if (v[4]) m_done = 1'b0;
  endtask

  task automatic read_rxd(input string tag);
    logic [7:0] v;
    bus_read(A_RXD, v);
    check({tag, "_rxd"}, v, m_rxd);
    m_avail = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [7:0] v;
    bus_read(A_STS, v);
    check({tag, "_sts"}, v, m_sts());
    check({tag, "_irq"}, irq, m_irq());
    check({tag, "_id"}, irq_id, m_id());
  endtask

  // Drives one 8N1 frame on rx_in (caller sits at a negedge) and updates the model.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int p = 0; p < 10; p++) begin
      rx_in = (p == 0) ? 1'b0 : (p == 9) ? stop : b[p-1];
      repeat (CPB) @(negedge clock);
    end
    rx_in = 1'b1;
    repeat (2) @(negedge clock);
    if (!stop) m_ferr = 1'b1;
    else if (m_avail) m_ovr = 1'b1;
    else begin m_avail = 1'b1; m_rxd = b; end
  endtask

  // Writes TXD, then watches tx_out, busy and done every cycle for 81 cycles.
  task automatic tx_frame(input logic [7:0] b);
    logic [80:0] act_w, exp_w, act_b, exp_b, act_d, exp_d;
    int pos;
    @(negedge clock); cs = 1'b0; wr = 1'b0; addr = A_TXD; in_data = b;
    m_done = 1'b0;
    @(negedge clock); wr = 1'b1; rd = 1'b0; addr = A_STS;
    for (int k = 0; k <= 80; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      pos = k / CPB;
      act_w[k] = tx_out;
      exp_w[k] = (pos == 0) ? 1'b0 : (pos <= 8) ? b[pos-1] : 1'b1;
      act_b[k] = out_data[0];
      exp_b[k] = (k < 80);
      act_d[k] = out_data[4];
      exp_d[k] = (k == 80);
    end
    cs = 1'b1; rd = 1'b1;
    m_done = 1'b1;
    check($sformatf("tx_wave_%02h", b), act_w, exp_w);
    check($sformatf("tx_busy_%02h", b), act_b, exp_b);
    check($sformatf("tx_done_%02h", b), act_d, exp_d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v, b;
    logic sb, ok;
    int unsigned op;

    reset = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = '0; in_data = '0; rx_in = 1'b1;
    m_ctl = '0; m_done = 0; m_avail = 0; m_ferr = 0; m_ovr = 0; m_rxd = '0;

    tbl[0] = '{1'b1, A_CTL, 8'hFF, CTL_MASK};
    tbl[1] = '{1'b1, A_CTL, 8'h05, 8'h05};
    tbl[2] = '{1'b0, A_STS, 8'h00, 8'h00};
    tbl[3] = '{1'b0, A_RXD, 8'h00, 8'h00};
    tbl[4] = '{1'b1, 3'd5,  8'hAA, 8'h00};
    tbl[5] = '{1'b1, 3'd7,  8'hFF, 8'h00};
    tbl[6] = '{1'b1, A_CLR, 8'h1C, 8'h00};
    tbl[7] = '{1'b1, A_CTL, 8'h00, 8'h00};

    repeat (3) @(negedge clock);
    #1;
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_irq", irq, 1'b0);
    check("rst_irq_id", irq_id, 3'd0);
    check("rst_out_data", out_data, 8'h00);
    reset = 1'b0;
    check_model("rst");

    foreach (tbl[i]) begin
      if (tbl[i].we) bus_write(tbl[i].a, tbl[i].wdata);
      bus_read(tbl[i].a, v);
      check($sformatf("tbl%0d_read", i), v, tbl[i].exp);
      check($sformatf("tbl%0d_irq", i), irq, 1'b0);
    end

    tx_frame(8'h55);
    check_model("tx55");
    wr_ctl(8'h01);
    tx_frame(8'hA3);
    check_model("txa3_irq");
    clr(8'h10);
    check_model("txa3_clr");

    wr_ctl(8'h02);
    rx_frame(8'h4B, 1'b1);
    check_model("rx4b");
    read_rxd("rx4b");
    check_model("rx4b_read");

    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    check_model("overrun");
    read_rxd("overrun");
    wr_ctl(8'h04);
    rx_frame(8'h7E, 1'b0);
    check_model("framing");
    clr(8'h0C);
    check_model("err_clr");

    // simultaneous read and write returns the pre-write value
    wr_ctl(8'h03);
    @(negedge clock); cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = A_CTL; in_data = 8'h06;
    #1 check("rdwr_pre", out_data, 8'h03);
    @(negedge clock); cs = 1'b1; rd = 1'b1; wr = 1'b1; m_ctl = 3'h6;
    bus_read(A_CTL, v);
    check("rdwr_post", v, 8'h06);

    // short low glitch must be rejected; a real frame right after must still land
    rx_in = 1'b0;
    repeat (2) @(negedge clock);
    rx_in = 1'b1;
    repeat (10) @(negedge clock);
    check_model("glitch");
    rx_frame(8'hB6, 1'b1);
    check_model("post_glitch");
    read_rxd("post_glitch");

    // TXD strobe held past the end of the frame triggers only once
    @(negedge clock); cs = 1'b0; wr = 1'b0; addr = A_TXD; in_data = 8'hC3; m_done = 1'b0;
    repeat (83) @(negedge clock);
    cs = 1'b1; wr = 1'b1; m_done = 1'b1;
    check_model("held_txd");
    check("held_tx_out", tx_out, 1'b1);

    // RXD read held across a frame completion must not clear the new byte
    fork
      rx_frame(8'h4D, 1'b1);
      begin
        repeat (75) @(negedge clock);
        cs = 1'b0; rd = 1'b0; addr = A_RXD;
      end
    join
    #1 check("held_rd_data", out_data, 8'h4D);
    cs = 1'b1; rd = 1'b1;
    check_model("held_rd");

    // reset in the middle of a frame
    bus_write(A_TXD, 8'h00);
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1 check("rst_mid_tx_out", tx_out, 1'b1);
    reset = 1'b0;
    m_ctl = '0; m_done = 0; m_avail = 0; m_ferr = 0; m_ovr = 0; m_rxd = '0;
    check_model("rst_mid");
    read_rxd("rst_mid");
    tx_frame(8'h96);
    check_model("after_rst_tx");

    for (int i = 0; i < 18; i++) begin
      op = $urandom_range(0, 6);
      case (op)
        0, 1, 2: begin
          b  = 8'($urandom);
          sb = ($urandom_range(0, 4) != 0);
          rx_frame(b, sb);
        end
        3: read_rxd("rnd");
        4: clr(8'($urandom));
        5: wr_ctl(8'($urandom));
        default: tx_frame(8'($urandom));
      endcase
      check_model($sformatf("rnd%0d", i));
    end

`ifdef UART_LOOPBACK_EN
    read_rxd("lb_pre");
    bus_write(A_CTL, 8'h08);
    m_ctl = 3'b000;
    bus_write(A_TXD, 8'h5A);
    ok = 1'b1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clock);
      #1 if (tx_out !== 1'b1) ok = 1'b0;
    end
    check("lb_tx_high", ok, 1'b1);
    m_done = 1'b1; m_avail = 1'b1; m_rxd = 8'h5A;
    read_rxd("lb");
    wr_ctl(8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_component.md
Name: uart_component

Overview:
Memory-mapped 8N1 UART peripheral sitting on the CPU's simple byte bus (chip select, read and write strobes, 3-bit address). It contains a transmit serializer and a receive deserializer. Status, control and data registers are exposed at the bus. A level interrupt and a priority-encoded interrupt ID are raised toward the CPU.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (integer ≥ 4).

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cs  in  1  chip select, active low
rd  in  1  read strobe, active low (qualified by cs)
wr  in  1  write strobe, active low (qualified by cs)
addr  in  3  register address
in_data  in  8  write data from CPU
out_data  out  8  read data to CPU
rx_in  in  1  serial receive line, idle high
tx_out  out  1  serial transmit line, idle high
irq  out  1  interrupt request, active high, level
irq_id  out  3  highest-priority pending enabled source

Behaviour:
- Reset values:
  - tx_out=1, out_data=0, irq=0, irq_id=0.
  - CTL=0, all status flags 0, RXD=0.
  - Both engines return to idle; a frame in progress is abandoned and tx_out goes high on the next cycle.
- Register map:
  - 0 CTL (RW): bit0 tx_done_ie, bit1 rx_avail_ie, bit2 rx_err_ie, bit3 loopback (see optional feature); other bits read 0.
  - 1 STS (R): bit0 tx_busy, bit1 rx_avail, bit2 framing_err, bit3 overrun, bit4 tx_done.
  - 2 TXD (W): writing starts a transmission.
  - 3 RXD (R): last received byte.
  - 4 CLR (W): write-1-to-clear for STS bits 2–4.
  - Addresses 5–7: read 0, writes ignored.
- Writes are captured on any clock edge with cs=0 and wr=0. A held strobe writes every cycle, but the TXD side effect triggers once only, on the first asserted cycle (wr high→low, or cs falling while wr is low).
- out_data is combinational: the addressed register when cs=0 and rd=0, else 0.
- Reading RXD clears rx_avail on the first asserted cycle only (edge-detected); data persists.
- Simultaneous rd and wr: the write takes effect and the read still returns the pre-write value.
- TX:
  - A TXD write while tx_busy=0 latches the byte, sets tx_busy and clears tx_done in that same edge.
  - tx_out is driven low (start bit) from the next cycle. Then 8 data bits, LSB first, then one stop bit (high), each CLKS_PER_BIT cycles.
  - At the end of the stop bit: tx_busy clears and tx_done sets, i.e. 10*CLKS_PER_BIT cycles after start.
  - A TXD write while tx_busy=1 is ignored.
- TX states: IDLE, START, DATA, STOP.
- RX:
  - rx_in passes through a 2-flop synchronizer.
  - A falling edge in IDLE enters START. The line is resampled at CLKS_PER_BIT/2; if high, the start is treated as a glitch and the engine returns to IDLE.
  - Each data bit is sampled at mid-bit, and the stop bit is sampled at mid-bit.
  - At stop sample:
    - stop=0: set framing_err, discard the byte.
    - else if rx_avail=1: set overrun, discard the new byte, keep the old RXD.
    - else: load RXD and set rx_avail.
  - After the stop sample the engine returns to IDLE, ready for the next start edge.
- RX states: IDLE, START, DATA, STOP.
- Interrupts:
  - irq = (tx_done & tx_done_ie) | (rx_avail & rx_avail_ie) | ((framing_err|overrun) & rx_err_ie).
  - irq_id priority: 1 = rx error, 2 = rx_avail, 3 = tx_done, 0 = none.
  - Both outputs are combinational from registered flags.
- Flag set and CLR in the same cycle: set wins.

Optional Feature:
UART_LOOPBACK_EN
- Defined: CTL bit3 is writable. When it is 1, the RX synchronizer input is the internal TX serial output instead of rx_in, and tx_out is held high.
- Undefined: CTL bit3 reads 0, writes to it are ignored, and RX always uses rx_in.

Decomposition:
- Package uart_pkg holds:
  - register address constants (CTL, STS, TXD, RXD, CLR);
  - STS and CTL bit indices;
  - irq_id codes;
  - TX/RX state enums.
- One sub-module, uart_tx_serializer, provides the TX engine. Ports: clock, reset, start, data[7:0], busy, done pulse, serial out.
- RX, the register file and interrupt logic stay in uart_component.

Test Plan (CLKS_PER_BIT=8):
- Reset: hold reset 3 cycles → tx_out=1, irq=0, irq_id=0, STS reads 0x00.
- Write 0x55 to TXD → tx_busy=1 next read; tx_out low 8 cycles, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then high; tx_done=1 at cycle 80.
- CTL=0x01, TXD=0xA3 → after frame irq=1, irq_id=3. Write 0x10 to CLR → irq=0.
- Drive frame 0x4B on rx_in with CTL=0x02 → rx_avail=1, irq_id=2. RXD reads 0x4B, then rx_avail=0.
- Two frames (0x11, 0x22) without reading RXD → overrun=1, RXD=0x11. Frame with stop bit 0 → framing_err=1, irq_id=1 when CTL=0x04.
- Reset asserted mid-TX frame → tx_out=1 next cycle, tx_busy=0, and a new TXD write starts a fresh frame.
